// File: rtl/wave_capture_if.sv
// Result port of wave_capture: period measurement plus status, valid/ready handshake.
// The master side (wave_capture) drives the result and the consumer drives meas_ready.
interface wave_capture_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 20
);
    logic              meas_valid;
    logic              meas_ready;
    logic [CNT_W-1:0]  period;
    logic              overflow;
    logic              dropped;
    logic              locked;
    logic [DATA_W-1:0] peak_max;
    logic [DATA_W-1:0] peak_min;

    modport master (
        output meas_valid, period, overflow, dropped, locked, peak_max, peak_min,
        input  meas_ready
    );

    modport slave (
        input  meas_valid, period, overflow, dropped, locked, peak_max, peak_min,
        output meas_ready
    );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: midscale crossing detector with hysteresis and period counter.
// Rising crossings (LOW -> >= HI_TH) end one period and start the next; a result
// is offered on the meas port with backpressure (extra results are dropped and
// flagged). Optional feature macro WAVE_CAP_PEAK_EN adds per-period max/min tracking;
// without it peak_max/peak_min are constant 0.
module wave_capture #(
    parameter int DATA_W     = 10,
    parameter int HYST       = 16,
    parameter int CNT_W      = 20,
    parameter int MIN_PERIOD = 16,
    parameter int LOCK_TOL   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    wave_capture_if.master    meas
);
    localparam int                MID     = 2 ** (DATA_W - 1);
    localparam logic [DATA_W-1:0] LO_TH   = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] HI_TH   = DATA_W'(MID + HYST);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARM_LO, HIGH, LOW} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Result produced by the crossing logic this cycle (not yet registered).
    logic               res_new;
    logic [CNT_W-1:0]   res_period;
    logic               res_ovf;
    logic [DATA_W-1:0]  res_pmax;
    logic [DATA_W-1:0]  res_pmin;
    logic               clear_lock;

    // Output/result registers.
    logic               meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               overflow_q, overflow_d;
    logic               dropped_q, dropped_d;
    logic               locked_q, locked_d;
    logic [CNT_W-1:0]   prev_q, prev_d;
    logic               have_prev_q, have_prev_d;

    logic               is_lo;
    logic               is_hi;
    logic               hs;
    logic               load;
    logic               drop;
    logic [CNT_W-1:0]   diff;

`ifdef WAVE_CAP_PEAK_EN
    logic [DATA_W-1:0]  run_max_q, run_max_d;
    logic [DATA_W-1:0]  run_min_q, run_min_d;
    logic [DATA_W-1:0]  peak_max_q, peak_max_d;
    logic [DATA_W-1:0]  peak_min_q, peak_min_d;
`endif

    assign is_lo = (sample_in < LO_TH);
    assign is_hi = (sample_in >= HI_TH);

    // Crossing FSM, period counter and per-period peak trackers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_new    = 1'b0;
        res_period = '0;
        res_ovf    = 1'b0;
        clear_lock = 1'b0;
`ifdef WAVE_CAP_PEAK_EN
        run_max_d  = run_max_q;
        run_min_d  = run_min_q;
        res_pmax   = run_max_q;
        res_pmin   = run_min_q;
`else
        res_pmax   = '0;
        res_pmin   = '0;
`endif
        if (sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_lo) state_d = ARM_LO;
                end
                ARM_LO: begin
                    // First rise only starts the count; there is no previous edge.
                    if (is_hi) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
`ifdef WAVE_CAP_PEAK_EN
                        run_max_d = sample_in;
                        run_min_d = sample_in;
`endif
                    end
                end
                HIGH, LOW: begin
                    if (state_q == LOW && is_hi && cnt_q >= CNT_W'(MIN_PERIOD)) begin
                        // cnt already includes the previous crossing sample, so it
                        // equals the sample distance between the two rises.
                        res_new    = 1'b1;
                        res_period = cnt_q;
                        state_d    = HIGH;
                        cnt_d      = CNT_W'(1);
`ifdef WAVE_CAP_PEAK_EN
                        run_max_d = sample_in;
                        run_min_d = sample_in;
`endif
                    end else if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                        // Counter would saturate: report a timeout and re-arm.
                        res_new    = 1'b1;
                        res_period = CNT_MAX;
                        res_ovf    = 1'b1;
                        clear_lock = 1'b1;
                        state_d    = IDLE;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == HIGH && is_lo) state_d = LOW;
`ifdef WAVE_CAP_PEAK_EN
                        if (sample_in > run_max_q) run_max_d = sample_in;
                        if (sample_in < run_min_q) run_min_d = sample_in;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign hs   = meas_valid_q & meas.meas_ready;
    assign load = res_new & (~meas_valid_q | hs);
    assign drop = res_new & ~load;
    assign diff = (res_period >= prev_q) ? (res_period - prev_q) : (prev_q - res_period);

    // Result register, handshake, drop flag and lock tracking.
    always_comb begin
        meas_valid_d = meas_valid_q;
        period_d     = period_q;
        overflow_d   = overflow_q;
        dropped_d    = dropped_q;
        locked_d     = locked_q;
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
`ifdef WAVE_CAP_PEAK_EN
        peak_max_d   = peak_max_q;
        peak_min_d   = peak_min_q;
`endif
        if (hs) begin
            meas_valid_d = 1'b0;
            dropped_d    = 1'b0;
        end
        if (load) begin
            meas_valid_d = 1'b1;
            period_d     = res_period;
            overflow_d   = res_ovf;
`ifdef WAVE_CAP_PEAK_EN
            peak_max_d   = res_pmax;
            peak_min_d   = res_pmin;
`endif
            if (!res_ovf) begin
                locked_d    = have_prev_q && (diff <= CNT_W'(LOCK_TOL));
                prev_d      = res_period;
                have_prev_d = 1'b1;
            end
        end
        if (drop) dropped_d = 1'b1;
        // A timeout always forgets the reference period, loaded or not.
        if (clear_lock) begin
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
        end
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            meas_valid_q <= 1'b0;
            period_q     <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= 1'b0;
            locked_q     <= 1'b0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
`ifdef WAVE_CAP_PEAK_EN
            run_max_q    <= '0;
            run_min_q    <= '0;
            peak_max_q   <= '0;
            peak_min_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            meas_valid_q <= meas_valid_d;
            period_q     <= period_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
            locked_q     <= locked_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
`ifdef WAVE_CAP_PEAK_EN
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            peak_max_q   <= peak_max_d;
            peak_min_q   <= peak_min_d;
`endif
        end
    end

    assign meas.meas_valid = meas_valid_q;
    assign meas.period     = period_q;
    assign meas.overflow   = overflow_q;
    assign meas.dropped    = dropped_q;
    assign meas.locked     = locked_q;
`ifdef WAVE_CAP_PEAK_EN
    assign meas.peak_max   = peak_max_q;
    assign meas.peak_min   = peak_min_q;
`else
    assign meas.peak_max   = '0;
    assign meas.peak_min   = '0;
`endif
endmodule

// File: tb/tb_wave_capture.sv
// Testbench for wave_capture: sine table scenarios plus hand-written corner sequences,
// checked through a scoreboard of expected results popped at each handshake.
module tb_wave_capture;
    localparam int DW    = 10;
    localparam int CW    = 10;
    localparam int P_MAX = 1023;
`ifdef WAVE_CAP_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;

    wave_capture_if #(.DATA_W(DW), .CNT_W(CW)) mif ();

    wave_capture #(.DATA_W(DW), .HYST(16), .CNT_W(CW), .MIN_PERIOD(16), .LOCK_TOL(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .meas         (mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        bit ovf;
        bit locked;
        bit dropped;
        int pmax;
        int pmin;
        bit chk_gap;
    } exp_t;

    typedef struct {
        int per;
        int mid;
        int amp;
        int nres;
        bit gaps;
        int exp_max;
        int exp_min;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_hs = 0;
    int   sidx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pk(input int v);
        return PEAK_ON ? v : 0;
    endfunction

    function automatic int sine_at(input int idx, input int per, input int mid, input int amp);
        real ph;
        ph = 2.0 * 3.14159265358979 * real'(idx % per) / real'(per);
        return mid + int'(real'(amp) * $sin(ph));
    endfunction

    task automatic push(input int per, input bit ovf, input bit lk, input bit dr,
                        input int mx, input int mn, input bit gap);
        exp_t e;
        e.period = per; e.ovf = ovf; e.locked = lk; e.dropped = dr;
        e.pmax = mx; e.pmin = mn; e.chk_gap = gap;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input bit v);
        sample_in    = DW'(s);
        sample_valid = v;
        tick();
    endtask

    task automatic run_sine(input int per, input int mid, input int amp, input int nsamp, input bit gaps);
        for (int i = 0; i < nsamp; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) drive(int'($urandom_range(0, 1023)), 1'b0);
            drive(sine_at(sidx, per, mid, amp), 1'b1);
            sidx++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard: every handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && mif.meas_valid && mif.meas_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got period=%0d ovf=%0d expected no result",
                         mif.period, mif.overflow);
            end else begin
                mon_e = sb.pop_front();
                $display("txn cyc=%0d period=%0d ovf=%0d locked=%0d dropped=%0d pmax=%0d pmin=%0d",
                         cyc, mif.period, mif.overflow, mif.locked, mif.dropped, mif.peak_max, mif.peak_min);
                check("period", int'(mif.period), mon_e.period);
                check("overflow", int'(mif.overflow), int'(mon_e.ovf));
                check("locked", int'(mif.locked), int'(mon_e.locked));
                check("dropped", int'(mif.dropped), int'(mon_e.dropped));
                check("peak_max", int'(mif.peak_max), mon_e.pmax);
                check("peak_min", int'(mif.peak_min), mon_e.pmin);
                if (mon_e.chk_gap) check("interval", cyc - last_hs, mon_e.period);
            end
            last_hs = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        int   first;
        int   held_p;
        int   changes;
        int   vcount;

        vt[0] = '{per: 512, mid: 512, amp: 511, nres: 3, gaps: 1'b0, exp_max: 1023, exp_min: 1};
        vt[1] = '{per: 256, mid: 500, amp: 400, nres: 3, gaps: 1'b0, exp_max: 900,  exp_min: 100};
        vt[2] = '{per: 128, mid: 512, amp: 300, nres: 4, gaps: 1'b1, exp_max: 812,  exp_min: 212};
        vt[3] = '{per: 64,  mid: 512, amp: 200, nres: 3, gaps: 1'b0, exp_max: 712,  exp_min: 312};

        mif.meas_ready = 1'b1;

        // Sine table: periodic results, locked from the second one.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            mif.meas_ready = 1'b1;
            sidx = 0;
            for (int r = 0; r < vt[v].nres; r++)
                push(vt[v].per, 1'b0, r > 0, 1'b0, pk(vt[v].exp_max), pk(vt[v].exp_min),
                     !vt[v].gaps && r > 0);
            run_sine(vt[v].per, vt[v].mid, vt[v].amp, (vt[v].nres + 1) * vt[v].per + vt[v].per / 4, vt[v].gaps);
            repeat (4) drive(vt[v].mid, 1'b1);
            check($sformatf("vec%0d_all_results", v), sb.size(), 0);
        end

        // Reset while a result is pending.
        do_reset();
        mif.meas_ready = 1'b0;
        sidx = 0;
        run_sine(512, 512, 511, 2 * 512 + 128, 1'b0);
        check("pending_before_reset", int'(mif.meas_valid), 1);
        rst_n = 1'b0;
        run_sine(512, 512, 511, 2, 1'b0);
        rst_n = 1'b1;
        check("rst_meas_valid", int'(mif.meas_valid), 0);
        check("rst_period", int'(mif.period), 0);
        check("rst_overflow", int'(mif.overflow), 0);
        check("rst_dropped", int'(mif.dropped), 0);
        check("rst_locked", int'(mif.locked), 0);
        check("rst_peak_max", int'(mif.peak_max), 0);
        check("rst_peak_min", int'(mif.peak_min), 0);
        mif.meas_ready = 1'b1;
        push(512, 1'b0, 1'b0, 1'b0, pk(1023), pk(1), 1'b0);
        first = -1;
        for (int i = 0; i < 1024; i++) begin
            run_sine(512, 512, 511, 1, 1'b0);
            if (mif.meas_valid && first < 0) first = i;
        end
        check("first_result_after_two_rises", int'(first > 500 && first < 1024), 1);
        check("reset_results", sb.size(), 0);

        // Backpressure: held result, drop, then one handshake.
        do_reset();
        mif.meas_ready = 1'b0;
        sidx = 0;
        run_sine(512, 512, 511, 1028, 1'b0);
        check("bp_first_valid", int'(mif.meas_valid), 1);
        held_p = int'(mif.period);
        check("bp_first_period", held_p, 512);
        changes = 0;
        while (sidx < 1640) begin
            run_sine(512, 512, 511, 1, 1'b0);
            if (int'(mif.period) != held_p || !mif.meas_valid) changes++;
        end
        check("bp_held_stable", changes, 0);
        check("bp_dropped_set", int'(mif.dropped), 1);
        push(512, 1'b0, 1'b0, 1'b1, pk(1023), pk(1), 1'b0);
        mif.meas_ready = 1'b1;
        run_sine(512, 512, 511, 1, 1'b0);
        check("bp_dropped_cleared", int'(mif.dropped), 0);
        check("bp_valid_cleared", int'(mif.meas_valid), 0);
        push(512, 1'b0, 1'b1, 1'b0, pk(1023), pk(1), 1'b0);
        run_sine(512, 512, 511, 2180 - sidx, 1'b0);
        check("bp_results", sb.size(), 0);

        // Noise inside the hysteresis band never produces a result.
        do_reset();
        mif.meas_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 5000; i++) begin
            drive((i % 2 == 1) ? 519 : 505, 1'b1);
            if (mif.meas_valid) vcount++;
        end
        check("band_noise_no_valid", vcount, 0);

        // Timeout after a locked sine, then recovery.
        do_reset();
        mif.meas_ready = 1'b1;
        sidx = 0;
        push(512, 1'b0, 1'b0, 1'b0, pk(1023), pk(1), 1'b0);
        push(512, 1'b0, 1'b1, 1'b0, pk(1023), pk(1), 1'b1);
        run_sine(512, 512, 511, 3 * 512 + 128, 1'b0);
        check("locked_before_timeout", int'(mif.locked), 1);
        push(P_MAX, 1'b1, 1'b0, 1'b0, pk(1023), pk(0), 1'b0);
        repeat (1100) drive(0, 1'b1);
        check("timeout_seen", sb.size(), 0);
        check("locked_after_timeout", int'(mif.locked), 0);
        sidx = 0;
        push(512, 1'b0, 1'b0, 1'b0, pk(1023), pk(1), 1'b0);
        push(512, 1'b0, 1'b1, 1'b0, pk(1023), pk(1), 1'b1);
        run_sine(512, 512, 511, 2 * 512 + 128, 1'b0);
        check("recovery_results", sb.size(), 0);

        // Short spike inside LOW rejected; MIN_PERIOD boundary 15 rejected / 16 accepted.
        do_reset();
        mif.meas_ready = 1'b1;
        push(25, 1'b0, 1'b0, 1'b0, pk(1000), pk(0), 1'b0);
        push(16, 1'b0, 1'b0, 1'b0, pk(1000), pk(0), 1'b0);
        drive(0, 1'b1);
        drive(1000, 1'b1);
        drive(0, 1'b1);
        repeat (3) drive(1000, 1'b1);
        repeat (20) drive(0, 1'b1);
        drive(1000, 1'b1);
        repeat (14) drive(0, 1'b1);
        drive(1000, 1'b1);
        drive(1000, 1'b1);
        repeat (4) drive(0, 1'b1);
        check("spike_results", sb.size(), 0);

        check("final_queue_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
